// File: rtl/riscv_pkg.sv
// Shared types for the pipeline hazard controller: scoreboard entry layout
// and the forwarding-select encoding for "read from register file".
package riscv_pkg;

    localparam int NREGS_DEFAULT = 32;
    localparam int SB_RD_W       = $clog2(NREGS_DEFAULT);

    // One in-flight instruction as seen by the hazard logic.
    typedef struct packed {
        logic               valid;
        logic [SB_RD_W-1:0] rd;
        logic               is_load;
    } sb_entry_t;

    localparam sb_entry_t SB_BUBBLE   = '0;
    localparam int        FWD_REGFILE = 0;

endpackage

// File: rtl/hazard_scoreboard.sv
// Shift register of in-flight destination registers, one entry per tracked
// stage after decode (index 0 = EX). Provides per-stage source matches for
// the forwardable stages and a load-use hit for stages still waiting on
// load data.
module hazard_scoreboard
    import riscv_pkg::*;
#(
    parameter int FWD_STAGES = 3,
    parameter int LOAD_LAT   = 1,
    parameter int RA_W       = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  hold,
    input  logic                  bubble,
    input  sb_entry_t             entry,
    input  logic [RA_W-1:0]       rs1,
    input  logic                  rs1_used,
    input  logic [RA_W-1:0]       rs2,
    input  logic                  rs2_used,
    output logic [FWD_STAGES-2:0] match_a,
    output logic [FWD_STAGES-2:0] match_b,
    output logic                  load_hit
);

    sb_entry_t          sb [FWD_STAGES];
    logic [SB_RD_W-1:0] rs1_x;
    logic [SB_RD_W-1:0] rs2_x;

    assign rs1_x = SB_RD_W'(rs1);
    assign rs2_x = SB_RD_W'(rs2);

    // Shift entries one stage older each unfrozen cycle; the oldest retires.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int k = 0; k < FWD_STAGES; k++) begin
                sb[k] <= SB_BUBBLE;
            end
        end else if (!hold) begin
            sb[0] <= bubble ? SB_BUBBLE : entry;
            for (int k = 1; k < FWD_STAGES; k++) begin
                sb[k] <= sb[k-1];
            end
        end
    end

    // Source matches for forwardable stages and the load-use window.
    always_comb begin
        match_a  = '0;
        match_b  = '0;
        load_hit = 1'b0;
        for (int k = 0; k < FWD_STAGES - 1; k++) begin
            match_a[k] = rs1_used && (rs1_x != '0) && sb[k].valid && (sb[k].rd == rs1_x);
            match_b[k] = rs2_used && (rs2_x != '0) && sb[k].valid && (sb[k].rd == rs2_x);
        end
        for (int k = 0; k < LOAD_LAT; k++) begin
            if ((match_a[k] || match_b[k]) && sb[k].is_load) begin
                load_hit = 1'b1;
            end
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, branch flushes, external
// memory-wait freezes and registered forwarding selects for EX.
// Optional performance counters are built when HAZARD_PERF_EN is defined.
//
// Priority (highest first): reset, ext_stall, e_b_taken, load-use, none.
// Stall/flush outputs are combinational; fwd_a/fwd_b are registered and
// describe the instruction currently in EX (0 = register file, k = result
// of stage k+1).
module hazard_ctrl
    import riscv_pkg::*;
#(
    parameter  int NREGS      = 32,
    parameter  int FWD_STAGES = 3,
    parameter  int LOAD_LAT   = 1,
    localparam int RA_W       = $clog2(NREGS),
    localparam int FWD_W      = $clog2(FWD_STAGES)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             d_valid,
    input  logic [RA_W-1:0]  d_rs1,
    input  logic [RA_W-1:0]  d_rs2,
    input  logic             d_rs1_used,
    input  logic             d_rs2_used,
    input  logic [RA_W-1:0]  d_rd,
    input  logic             d_regwrite,
    input  logic             d_is_load,
    input  logic             e_b_taken,
    input  logic             ext_stall,
    output logic             stall_f,
    output logic             stall_d,
    output logic             stall_e,
    output logic             flush_d,
    output logic             flush_e,
`ifdef HAZARD_PERF_EN
    output logic [31:0]      perf_stall_cnt,
    output logic [31:0]      perf_flush_cnt,
`endif
    output logic [FWD_W-1:0] fwd_a,
    output logic [FWD_W-1:0] fwd_b
);

    logic [FWD_STAGES-2:0] match_a;
    logic [FWD_STAGES-2:0] match_b;
    logic                  load_hit;
    logic                  load_use;
    logic                  bubble;
    sb_entry_t             entry;
    logic [FWD_W-1:0]      fwd_a_nxt;
    logic [FWD_W-1:0]      fwd_b_nxt;

    // Destination is tracked only when it is really written and is not x0.
    assign entry.valid   = d_regwrite && (d_rd != '0);
    assign entry.rd      = SB_RD_W'(d_rd);
    assign entry.is_load = d_is_load;

    assign load_use = d_valid && load_hit;
    assign bubble   = e_b_taken || load_use || !d_valid;

    hazard_scoreboard #(
        .FWD_STAGES (FWD_STAGES),
        .LOAD_LAT   (LOAD_LAT),
        .RA_W       (RA_W)
    ) u_scoreboard (
        .clk      (clk),
        .reset    (reset),
        .hold     (ext_stall),
        .bubble   (bubble),
        .entry    (entry),
        .rs1      (d_rs1),
        .rs1_used (d_rs1_used),
        .rs2      (d_rs2),
        .rs2_used (d_rs2_used),
        .match_a  (match_a),
        .match_b  (match_b),
        .load_hit (load_hit)
    );

    // Stall/flush decision in priority order.
    always_comb begin
        stall_f = 1'b0;
        stall_d = 1'b0;
        stall_e = 1'b0;
        flush_d = 1'b0;
        flush_e = 1'b0;
        if (!reset) begin
            flush_d = 1'b1;
            flush_e = 1'b1;
        end else if (ext_stall) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            stall_e = 1'b1;
        end else if (e_b_taken) begin
            flush_d = 1'b1;
            flush_e = 1'b1;
        end else if (load_use) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            flush_e = 1'b1;
        end
    end

    // Youngest matching stage wins: scan oldest to youngest, last hit sticks.
    always_comb begin
        fwd_a_nxt = FWD_W'(FWD_REGFILE);
        fwd_b_nxt = FWD_W'(FWD_REGFILE);
        for (int k = FWD_STAGES - 1; k >= 1; k--) begin
            if (match_a[k-1]) fwd_a_nxt = FWD_W'(k);
            if (match_b[k-1]) fwd_b_nxt = FWD_W'(k);
        end
    end

    // Forwarding selects follow the decode entry into EX; bubbles read regfile.
    always_ff @(posedge clk) begin
        if (!reset) begin
            fwd_a <= FWD_W'(FWD_REGFILE);
            fwd_b <= FWD_W'(FWD_REGFILE);
        end else if (!ext_stall) begin
            if (bubble) begin
                fwd_a <= FWD_W'(FWD_REGFILE);
                fwd_b <= FWD_W'(FWD_REGFILE);
            end else begin
                fwd_a <= fwd_a_nxt;
                fwd_b <= fwd_b_nxt;
            end
        end
    end

`ifdef HAZARD_PERF_EN
    logic stall_event;
    logic flush_event;

    assign stall_event = !ext_stall && !e_b_taken && load_use;
    assign flush_event = !ext_stall && e_b_taken;

    // Saturating event counters; frozen cycles are not counted.
    always_ff @(posedge clk) begin
        if (!reset) begin
            perf_stall_cnt <= '0;
            perf_flush_cnt <= '0;
        end else begin
            if (stall_event && (perf_stall_cnt != 32'hFFFF_FFFF)) begin
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            end
            if (flush_event && (perf_flush_cnt != 32'hFFFF_FFFF)) begin
                perf_flush_cnt <= perf_flush_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl (NREGS=32, FWD_STAGES=3, LOAD_LAT=1).
// Each driven cycle pushes its hand-computed expected outputs
// {stall_f, stall_d, stall_e, flush_d, flush_e, fwd_a, fwd_b} onto exp_q;
// a monitor on the falling edge pops and compares.
module tb_hazard_ctrl;

    localparam logic [4:0] C_NONE = 5'b00000;
    localparam logic [4:0] C_LU   = 5'b11001;
    localparam logic [4:0] C_BR   = 5'b00011;
    localparam logic [4:0] C_EXT  = 5'b11100;
    localparam logic [4:0] C_RST  = 5'b00011;

    logic       clk;
    logic       reset;
    logic       d_valid;
    logic [4:0] d_rs1;
    logic [4:0] d_rs2;
    logic       d_rs1_used;
    logic       d_rs2_used;
    logic [4:0] d_rd;
    logic       d_regwrite;
    logic       d_is_load;
    logic       e_b_taken;
    logic       ext_stall;
    logic       stall_f;
    logic       stall_d;
    logic       stall_e;
    logic       flush_d;
    logic       flush_e;
    logic [1:0] fwd_a;
    logic [1:0] fwd_b;
`ifdef HAZARD_PERF_EN
    logic [31:0] perf_stall_cnt;
    logic [31:0] perf_flush_cnt;
`endif

    // {chk_perf, perf_stall, perf_flush, ctl[8:0]}
    logic [73:0] exp_q[$];
    string       name_q[$];
    int          n_cmp;
    int          n_fail;

    logic        pend_chk;
    logic [31:0] pend_ps;
    logic [31:0] pend_pf;

    hazard_ctrl #(
        .NREGS      (32),
        .FWD_STAGES (3),
        .LOAD_LAT   (1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .d_valid    (d_valid),
        .d_rs1      (d_rs1),
        .d_rs2      (d_rs2),
        .d_rs1_used (d_rs1_used),
        .d_rs2_used (d_rs2_used),
        .d_rd       (d_rd),
        .d_regwrite (d_regwrite),
        .d_is_load  (d_is_load),
        .e_b_taken  (e_b_taken),
        .ext_stall  (ext_stall),
        .stall_f    (stall_f),
        .stall_d    (stall_d),
        .stall_e    (stall_e),
        .flush_d    (flush_d),
        .flush_e    (flush_e),
`ifdef HAZARD_PERF_EN
        .perf_stall_cnt (perf_stall_cnt),
        .perf_flush_cnt (perf_flush_cnt),
`endif
        .fwd_a      (fwd_a),
        .fwd_b      (fwd_b)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [8:0] ex(input logic [4:0] c, input int fa, input int fb);
        logic [1:0] a;
        logic [1:0] b;
        a = fa[1:0];
        b = fb[1:0];
        return {c, a, b};
    endfunction

    // Drive one decode cycle and queue its expected outputs.
    task automatic drive(input logic v, input logic [4:0] rs1, input logic u1,
                         input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                         input logic rw, input logic ld, input logic bt,
                         input logic ext, input logic rst, input logic [8:0] e,
                         input string nm);
        @(posedge clk);
        #1;
        d_valid    = v;
        d_rs1      = rs1;
        d_rs1_used = u1;
        d_rs2      = rs2;
        d_rs2_used = u2;
        d_rd       = rd;
        d_regwrite = rw;
        d_is_load  = ld;
        e_b_taken  = bt;
        ext_stall  = ext;
        reset      = rst;
        exp_q.push_back({pend_chk, pend_ps, pend_pf, e});
        name_q.push_back(nm);
        pend_chk = 1'b0;
    endtask

    task automatic nop(input logic bt, input logic [8:0] e, input string nm);
        drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, bt, 1'b0, 1'b1, e, nm);
    endtask

    task automatic perf_expect(input logic [31:0] ps, input logic [31:0] pf);
        pend_chk = 1'b1;
        pend_ps  = ps;
        pend_pf  = pf;
    endtask

    // Scoreboard monitor: compare one queued expectation per falling edge.
    always @(negedge clk) begin
        logic [73:0] e;
        logic [8:0]  act;
        string       nm;
        if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            nm  = name_q.pop_front();
            act = {stall_f, stall_d, stall_e, flush_d, flush_e, fwd_a, fwd_b};
            n_cmp++;
            if (act !== e[8:0]) begin
                n_fail++;
                $display("FAIL %s: got sf,sd,se,fd,fe,fa,fb=%b expected %b", nm, act, e[8:0]);
            end
`ifdef HAZARD_PERF_EN
            if (e[73]) begin
                n_cmp++;
                if (perf_stall_cnt !== e[72:41] || perf_flush_cnt !== e[40:9]) begin
                    n_fail++;
                    $display("FAIL %s: got stall_cnt=%0d flush_cnt=%0d expected %0d %0d",
                             nm, perf_stall_cnt, perf_flush_cnt, e[72:41], e[40:9]);
                end
            end
`endif
        end
    end

    // Stimulus
    initial begin
        n_cmp      = 0;
        n_fail     = 0;
        pend_chk   = 1'b0;
        pend_ps    = '0;
        pend_pf    = '0;
        reset      = 1'b0;
        d_valid    = 1'b0;
        d_rs1      = '0;
        d_rs2      = '0;
        d_rs1_used = 1'b0;
        d_rs2_used = 1'b0;
        d_rd       = '0;
        d_regwrite = 1'b0;
        d_is_load  = 1'b0;
        e_b_taken  = 1'b0;
        ext_stall  = 1'b0;
        repeat (2) @(posedge clk);

        // Reset held low: flushes asserted, fwd cleared.
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ex(C_RST, 0, 0), "reset_state");

        // Back-to-back ALU dependence: add x5; sub x6,x5,x1.
        drive(1, 1, 1, 2, 1, 5, 1, 0, 0, 0, 1, ex(C_NONE, 0, 0), "alu_add");
        drive(1, 5, 1, 1, 1, 6, 1, 0, 0, 0, 1, ex(C_NONE, 0, 0), "alu_sub_no_stall");
        nop(0, ex(C_NONE, 1, 0), "alu_fwd_a_ex");
        drive(1, 5, 1, 6, 1, 9, 1, 0, 0, 0, 1, ex(C_NONE, 0, 0), "alu_far_dep");
        nop(0, ex(C_NONE, 0, 2), "fwd_b_mem_only");
        nop(0, ex(C_NONE, 0, 0), "drain_1");
        nop(0, ex(C_NONE, 0, 0), "drain_2");

        // Load-use: lw x7; add x8,x7,x2.
        drive(1, 3, 1, 0, 0, 7, 1, 1, 0, 0, 1, ex(C_NONE, 0, 0), "lw_x7");
        drive(1, 7, 1, 2, 1, 8, 1, 0, 0, 0, 1, ex(C_LU, 0, 0), "load_use_stall");
        drive(1, 7, 1, 2, 1, 8, 1, 0, 0, 0, 1, ex(C_NONE, 0, 0), "load_use_release");
        nop(0, ex(C_NONE, 2, 0), "load_fwd_a_2");
        nop(0, ex(C_NONE, 0, 0), "drain_3");
        nop(0, ex(C_NONE, 0, 0), "drain_4");

        // Taken branch over a load-use hazard in decode.
        drive(1, 3, 1, 0, 0, 7, 1, 1, 0, 0, 1, ex(C_NONE, 0, 0), "lw_x7_b");
        drive(1, 7, 1, 2, 1, 8, 1, 0, 1, 0, 1, ex(C_BR, 0, 0), "branch_over_lu");
        drive(1, 7, 1, 2, 1, 8, 1, 0, 0, 0, 1, ex(C_NONE, 0, 0), "after_branch_no_stall");
        nop(0, ex(C_NONE, 2, 0), "after_branch_fwd");
        nop(0, ex(C_NONE, 0, 0), "drain_5");
        nop(0, ex(C_NONE, 0, 0), "drain_6");

        // ext_stall for 3 cycles with a taken branch in EX.
        drive(1, 1, 1, 2, 1, 5, 1, 0, 0, 0, 1, ex(C_NONE, 0, 0), "pre_ext_add");
        drive(1, 5, 1, 1, 1, 6, 1, 0, 0, 0, 1, ex(C_NONE, 0, 0), "pre_ext_sub");
        for (int i = 0; i < 3; i++) begin
            drive(1, 6, 1, 0, 0, 10, 1, 0, 1, 1, 1, ex(C_EXT, 1, 0), "ext_stall_hold");
        end
        drive(1, 6, 1, 0, 0, 10, 1, 0, 1, 0, 1, ex(C_BR, 1, 0), "flush_after_ext");
        nop(0, ex(C_NONE, 0, 0), "post_flush_fwd");
        nop(0, ex(C_NONE, 0, 0), "drain_7");

        // x0 dependence: lw x0; add x1,x0,x0.
        drive(1, 3, 1, 0, 0, 0, 1, 1, 0, 0, 1, ex(C_NONE, 0, 0), "lw_x0");
        drive(1, 0, 1, 0, 1, 1, 1, 0, 0, 0, 1, ex(C_NONE, 0, 0), "x0_no_stall");
        nop(0, ex(C_NONE, 0, 0), "x0_fwd_zero");

        // Unused source must not stall; used rs2 must.
        drive(1, 3, 1, 0, 0, 7, 1, 1, 0, 0, 1, ex(C_NONE, 0, 0), "lw_x7_c");
        drive(1, 3, 1, 7, 0, 11, 1, 0, 0, 0, 1, ex(C_NONE, 0, 0), "unused_rs2_no_stall");
        nop(0, ex(C_NONE, 0, 0), "unused_rs2_fwd");
        drive(1, 3, 1, 0, 0, 12, 1, 1, 0, 0, 1, ex(C_NONE, 0, 0), "lw_x12");
        drive(1, 0, 0, 12, 1, 13, 1, 0, 0, 0, 1, ex(C_LU, 0, 0), "load_use_rs2");
        drive(1, 0, 0, 12, 1, 13, 1, 0, 0, 0, 1, ex(C_NONE, 0, 0), "load_use_rs2_release");
        nop(0, ex(C_NONE, 0, 2), "load_fwd_b_2");

        // Reset during a pending load-use hazard discards it.
        drive(1, 3, 1, 0, 0, 7, 1, 1, 0, 0, 1, ex(C_NONE, 0, 0), "lw_x7_d");
        drive(1, 7, 1, 2, 1, 8, 1, 0, 0, 0, 0, ex(C_RST, 0, 0), "reset_mid_hazard");
        perf_expect(32'd0, 32'd0);
        drive(1, 7, 1, 2, 1, 8, 1, 0, 0, 0, 1, ex(C_NONE, 0, 0), "after_reset_no_stall");
        nop(0, ex(C_NONE, 0, 0), "drain_8");
        nop(0, ex(C_NONE, 0, 0), "drain_9");
        nop(0, ex(C_NONE, 0, 0), "drain_10");

        // Two load-use stalls and one branch flush.
        drive(1, 3, 1, 0, 0, 7, 1, 1, 0, 0, 1, ex(C_NONE, 0, 0), "lw_x7_e");
        drive(1, 7, 1, 2, 1, 8, 1, 0, 0, 0, 1, ex(C_LU, 0, 0), "lu_stall_1");
        drive(1, 7, 1, 2, 1, 8, 1, 0, 0, 0, 1, ex(C_NONE, 0, 0), "lu_release_1");
        drive(1, 3, 1, 0, 0, 9, 1, 1, 0, 0, 1, ex(C_NONE, 2, 0), "lw_x9");
        drive(1, 9, 1, 8, 1, 10, 1, 0, 0, 0, 1, ex(C_LU, 0, 0), "lu_stall_2");
        drive(1, 9, 1, 8, 1, 10, 1, 0, 0, 0, 1, ex(C_NONE, 0, 0), "lu_release_2");
        nop(1, ex(C_BR, 2, 0), "branch_flush");
        perf_expect(32'd2, 32'd1);
        nop(0, ex(C_NONE, 0, 0), "perf_counts");

        // Bounded drain of the expected queue.
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
            @(negedge clk);
        end
        @(negedge clk);
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
